// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses same-cycle writeback,
// tracks in-flight destinations in a scoreboard and stalls on RAW/WAW hazards.
module operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_we,

    output logic [ADDR_WIDTH-1:0] rf_rs_addr,
    output logic [ADDR_WIDTH-1:0] rf_rt_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs_data,
    input  logic [DATA_WIDTH-1:0] rf_rt_data,

    input  logic                  wb_write,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs_data,
    output logic [DATA_WIDTH-1:0] out_rt_data,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_we,

    output logic [NUM_REGS-1:0]   pending
);

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_rs_data;
    logic [DATA_WIDTH-1:0] r_out_rt_data;
    logic [ADDR_WIDTH-1:0] r_out_rd;
    logic                  r_out_rd_we;
    logic [NUM_REGS-1:0]   r_pending;

    logic                  w_byp_a;
    logic                  w_byp_b;
    logic                  w_byp_d;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_hz_a;
    logic                  w_hz_b;
    logic                  w_hz_w;
    logic                  w_stall;
    logic                  w_out_free;
    logic                  w_accept;
    logic [NUM_REGS-1:0]   w_pending_next;

    assign rf_rs_addr = in_rs;
    assign rf_rt_addr = in_rt;

    // The register file writes on the edge, so a same-cycle read sees stale data
    // unless the writeback value is forwarded here.
    assign w_byp_a = wb_write && (wb_addr == in_rs);
    assign w_byp_b = wb_write && (wb_addr == in_rt);
    assign w_byp_d = wb_write && (wb_addr == in_rd);
    assign w_op_a  = w_byp_a ? wb_data : rf_rs_data;
    assign w_op_b  = w_byp_b ? wb_data : rf_rt_data;

    // A pending register being written back this cycle is no longer a hazard.
    assign w_hz_a  = r_pending[in_rs] && !w_byp_a;
    assign w_hz_b  = r_pending[in_rt] && !w_byp_b;
    assign w_hz_w  = in_rd_we && r_pending[in_rd] && !w_byp_d;
    assign w_stall = w_hz_a || w_hz_b || w_hz_w;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = reset_n && !w_stall && w_out_free;
    assign w_accept   = in_valid && in_ready;

    // NOTE: combinational logic uses blocking assignments and assigns a default
    // first, so no path leaves the signal unassigned and no latch is inferred.
    always_comb begin
        w_pending_next = r_pending;
        if (wb_write)
            w_pending_next[wb_addr] = 1'b0;
        // Set is applied after clear so a new writer wins over a retiring one.
        if (w_accept && in_rd_we)
            w_pending_next[in_rd] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments; the reset is synchronous, so it
    // is sampled on the clock edge rather than listed in the sensitivity list.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_rs_data <= '0;
            r_out_rt_data <= '0;
            r_out_rd      <= '0;
            r_out_rd_we   <= 1'b0;
            r_pending     <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_accept) begin
                r_out_valid   <= 1'b1;
                r_out_rs_data <= w_op_a;
                r_out_rt_data <= w_op_b;
                r_out_rd      <= in_rd;
                r_out_rd_we   <= in_rd_we;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rs_data = r_out_rs_data;
    assign out_rt_data = r_out_rt_data;
    assign out_rd      = r_out_rd;
    assign out_rd_we   = r_out_rd_we;
    assign pending     = r_pending;

endmodule
